// File: rtl/lfsr_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_checker_if
// Purpose : groups the serial data input and the lock/error status outputs of
//           lfsr_checker into one bundle so the checker and whatever feeds it
//           share a single connection.
// Signals : din         received serial bit from the 4-bit XNOR LFSR source
//           din_valid   din is meaningful this cycle
//           locked      checker is in the LOCKED state
//           err_pulse   one-cycle flag per misprediction while locked
//           err_count   saturating misprediction count (8 bits)
//           sync_state  FSM state: SEED=0, VERIFY=1, LOCKED=2
// Modports: master drives din/din_valid and observes status (the source side),
//           slave is the checker itself.
// ---------------------------------------------------------------------------
interface lfsr_checker_if;
   logic       din;
   logic       din_valid;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_count;
   logic [1:0] sync_state;

   // Source side: supplies the bit stream and watches the checker status
   modport master (
      output din,
      output din_valid,
      input  locked,
      input  err_pulse,
      input  err_count,
      input  sync_state
   );

   // Checker side: consumes the bit stream and reports lock/error status
   modport slave (
      input  din,
      input  din_valid,
      output locked,
      output err_pulse,
      output err_count,
      output sync_state
   );
endinterface

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
// Purpose : self-synchronising checker for a 4-bit XNOR LFSR bit stream
//           (recurrence b(t+4) = ~(b(t) ^ b(t+1))). It seeds a 4-bit history
//           from the incoming stream, verifies a run of correct predictions,
//           then stays locked and flags every misprediction until too many
//           consecutive errors drop the lock.
// Params  : VERIFY_LEN  consecutive correct predictions needed to lock (1..15)
//           LOSS_LEN    consecutive mispredictions that drop lock (1..7)
// Ports   : clk         single clock, everything updates on its rising edge
//           clr         synchronous active-high reset, wins over din_valid
//           bus         lfsr_checker_if.slave (din, din_valid in;
//                       locked, err_pulse, err_count, sync_state out)
// Config  : LFSR_CHK_ERRCNT_EN defined   -> err_count is a saturating 8-bit
//                                           count of mispredictions in LOCKED
//           LFSR_CHK_ERRCNT_EN undefined -> no counter, err_count tied to 0
// ---------------------------------------------------------------------------
module lfsr_checker #(
   parameter int VERIFY_LEN = 8,
   parameter int LOSS_LEN   = 3
) (
   input  logic          clk,
   input  logic          clr,
   lfsr_checker_if.slave bus
);

   localparam logic [1:0] SEED   = 2'd0;
   localparam logic [1:0] VERIFY = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   // Counters compare against "length minus one" so the transition fires on
   // the sample that completes the run.
   localparam logic [3:0] VERIFY_LAST = 4'(VERIFY_LEN - 1);
   localparam logic [2:0] LOSS_LAST   = 3'(LOSS_LEN - 1);
   localparam logic [2:0] SEED_FULL   = 3'd4;

   logic [3:0] hist_q, hist_d;
   logic [2:0] seedCnt_q, seedCnt_d;
   logic [3:0] goodRun_q, goodRun_d;
   logic [2:0] badRun_q, badRun_d;
   logic [1:0] state_q, state_d;
   logic       locked_q, locked_d;
   logic       errPulse_q, errPulse_d;

   logic [3:0] histNext;
   logic       predBit;
   logic       bitMatch;
   logic       histAllOnes;

   // The history always takes the received bit, even a wrong one, so a single
   // corrupted bit keeps poisoning the next two predictions that use it.
   // 1111 is the XNOR generator's lock-up pattern and can never come from a
   // running source, so it is treated as "not a usable seed".
   assign histNext    = {hist_q[2:0], bus.din};
   assign predBit     = ~(hist_q[3] ^ hist_q[2]);
   assign bitMatch    = (bus.din == predBit);
   assign histAllOnes = (histNext == 4'b1111);

   // Next-state logic: nothing moves unless din_valid is high, apart from
   // err_pulse, which defaults low so it only ever lasts one cycle.
   always_comb begin
      hist_d     = hist_q;
      seedCnt_d  = seedCnt_q;
      goodRun_d  = goodRun_q;
      badRun_d   = badRun_q;
      state_d    = state_q;
      errPulse_d = 1'b0;

      if (bus.din_valid) begin
         hist_d = histNext;
         case (state_q)
            SEED: begin
               if (seedCnt_q != SEED_FULL) begin
                  seedCnt_d = seedCnt_q + 3'd1;
                  if (seedCnt_q == 3'd3 && !histAllOnes) begin
                     state_d = VERIFY;
                  end
               end else if (!histAllOnes) begin
                  state_d = VERIFY;
               end
            end

            VERIFY: begin
               if (!bitMatch || histAllOnes) begin
                  state_d   = SEED;
                  seedCnt_d = SEED_FULL;
                  goodRun_d = 4'd0;
                  badRun_d  = 3'd0;
               end else if (goodRun_q == VERIFY_LAST) begin
                  state_d   = LOCKED;
                  goodRun_d = 4'd0;
               end else begin
                  goodRun_d = goodRun_q + 4'd1;
               end
            end

            LOCKED: begin
               if (bitMatch) begin
                  badRun_d = 3'd0;
               end else begin
                  errPulse_d = 1'b1;
                  if (badRun_q == LOSS_LAST) begin
                     state_d   = SEED;
                     seedCnt_d = SEED_FULL;
                     goodRun_d = 4'd0;
                     badRun_d  = 3'd0;
                  end else begin
                     badRun_d = badRun_q + 3'd1;
                  end
               end
            end

            default: begin
               state_d   = SEED;
               seedCnt_d = 3'd0;
               goodRun_d = 4'd0;
               badRun_d  = 3'd0;
            end
         endcase
      end

      locked_d = (state_d == LOCKED);
   end

   // State registers; locked is registered from the next state so it drops
   // in the same cycle sync_state leaves LOCKED.
   always_ff @(posedge clk) begin
      if (clr) begin
         hist_q     <= 4'd0;
         seedCnt_q  <= 3'd0;
         goodRun_q  <= 4'd0;
         badRun_q   <= 3'd0;
         state_q    <= SEED;
         locked_q   <= 1'b0;
         errPulse_q <= 1'b0;
      end else begin
         hist_q     <= hist_d;
         seedCnt_q  <= seedCnt_d;
         goodRun_q  <= goodRun_d;
         badRun_q   <= badRun_d;
         state_q    <= state_d;
         locked_q   <= locked_d;
         errPulse_q <= errPulse_d;
      end
   end

   assign bus.locked     = locked_q;
   assign bus.err_pulse  = errPulse_q;
   assign bus.sync_state = state_q;

`ifdef LFSR_CHK_ERRCNT_EN
   logic [7:0] errCnt_q, errCnt_d;

   // Error counter follows the pulse and sticks at 255; losing lock leaves it
   // alone so the total survives resynchronisation.
   always_comb begin
      errCnt_d = errCnt_q;
      if (errPulse_d && errCnt_q != 8'hFF) begin
         errCnt_d = errCnt_q + 8'd1;
      end
   end

   // Only clr clears the count.
   always_ff @(posedge clk) begin
      if (clr) begin
         errCnt_q <= 8'd0;
      end else begin
         errCnt_q <= errCnt_d;
      end
   end

   assign bus.err_count = errCnt_q;
`else
   assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
// Purpose : directed self-checking bench for lfsr_checker. Drives the period-15
//           XNOR LFSR stream (optionally with flipped bits), constant-one input,
//           idle cycles and resets, and compares all status outputs against
//           hand-worked expected values after each step.
// Config  : expected err_count follows LFSR_CHK_ERRCNT_EN (0 when undefined).
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

`ifdef LFSR_CHK_ERRCNT_EN
   localparam bit ErrCntEn = 1'b1;
`else
   localparam bit ErrCntEn = 1'b0;
`endif

   logic clk;
   logic clr;
   int   checks;
   int   errors;
   int   gIdx;

   // One period of the generator output, first bit sent after reset first
   logic genBits [0:14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   // Hand-worked sync_state after each of the first 15 bits from reset
   logic [1:0] lockStates [0:14] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                     2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                     2'd2};

   lfsr_checker_if bus ();

   lfsr_checker #(
      .VERIFY_LEN (8),
      .LOSS_LEN   (3)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the summary");
      $fatal(1, "[TB] watchdog");
   end

   // Drive one cycle of inputs on the falling edge, then return 1 unit after
   // the next rising edge so outputs are sampled away from the clock edge.
   task automatic applyStimulus(input logic c, input logic v, input logic d);
      @(negedge clk);
      clr           = c;
      bus.din_valid = v;
      bus.din       = d;
      @(posedge clk);
      #1;
   endtask

   // Send the next generator bit, optionally inverted
   task automatic feedGen(input logic flip);
      applyStimulus(1'b0, 1'b1, genBits[gIdx % 15] ^ flip);
      gIdx++;
   endtask

   // Compare every status output against the expected values
   task automatic checkOutput(input string tag, input logic expLocked,
                              input logic [1:0] expState, input logic expPulse,
                              input int expErr);
      logic [7:0] wantErr;
      wantErr = ErrCntEn ? 8'(expErr) : 8'd0;
      checks++;
      assert (bus.locked === expLocked) else begin
         errors++;
         $error("[TB] FAIL %s locked got %0b want %0b", tag, bus.locked, expLocked);
      end
      checks++;
      assert (bus.sync_state === expState) else begin
         errors++;
         $error("[TB] FAIL %s sync_state got %0d want %0d", tag, bus.sync_state, expState);
      end
      checks++;
      assert (bus.err_pulse === expPulse) else begin
         errors++;
         $error("[TB] FAIL %s err_pulse got %0b want %0b", tag, bus.err_pulse, expPulse);
      end
      checks++;
      assert (bus.err_count === wantErr) else begin
         errors++;
         $error("[TB] FAIL %s err_count got %0d want %0d", tag, bus.err_count, wantErr);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      gIdx          = 0;
      clr           = 1'b0;
      bus.din       = 1'b0;
      bus.din_valid = 1'b0;

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("reset", 1'b0, 2'd0, 1'b0, 0);

      // Clean stream: VERIFY after bit 4, LOCKED after bit 12
      for (int i = 0; i < 15; i++) begin
         feedGen(1'b0);
         checkOutput($sformatf("lock bit%0d", i + 1), (i >= 11), lockStates[i], 1'b0, 0);
      end

      // Idle cycle holds everything
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("idle locked", 1'b1, 2'd2, 1'b0, 0);

      // Single flipped bit: errors on the flip and the two later predictions
      // that read it, bad-run never reaches 3
      feedGen(1'b1);
      checkOutput("flip bit16", 1'b1, 2'd2, 1'b1, 1);
      feedGen(1'b0);
      checkOutput("flip bit17", 1'b1, 2'd2, 1'b0, 1);
      feedGen(1'b0);
      checkOutput("flip bit18", 1'b1, 2'd2, 1'b0, 1);
      feedGen(1'b0);
      checkOutput("flip bit19", 1'b1, 2'd2, 1'b1, 2);
      feedGen(1'b0);
      checkOutput("flip bit20", 1'b1, 2'd2, 1'b1, 3);
      feedGen(1'b0);
      checkOutput("flip bit21", 1'b1, 2'd2, 1'b0, 3);
      for (int i = 0; i < 9; i++) feedGen(1'b0);
      checkOutput("flip recovered", 1'b1, 2'd2, 1'b0, 3);

      // Three inverted bits drop the lock
      feedGen(1'b1);
      checkOutput("loss err1", 1'b1, 2'd2, 1'b1, 4);
      feedGen(1'b1);
      checkOutput("loss err2", 1'b1, 2'd2, 1'b1, 5);
      feedGen(1'b1);
      checkOutput("loss err3", 1'b0, 2'd0, 1'b1, 6);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("loss idle", 1'b0, 2'd0, 1'b0, 6);

      // VERIFY mismatch returns to SEED; 1111 history holds SEED until broken
      applyStimulus(1'b1, 1'b0, 1'b0);
      gIdx = 0;
      for (int i = 0; i < 4; i++) feedGen(1'b0);
      checkOutput("verify entry", 1'b0, 2'd1, 1'b0, 0);
      feedGen(1'b1);
      checkOutput("verify miss", 1'b0, 2'd0, 1'b0, 0);
      feedGen(1'b0);
      checkOutput("ones hold a", 1'b0, 2'd0, 1'b0, 0);
      feedGen(1'b0);
      checkOutput("ones hold b", 1'b0, 2'd0, 1'b0, 0);
      feedGen(1'b0);
      checkOutput("ones broken", 1'b0, 2'd1, 1'b0, 0);
      feedGen(1'b0);
      checkOutput("verify miss2", 1'b0, 2'd0, 1'b0, 0);

      // Constant ones never leave SEED
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkOutput($sformatf("ones bit%0d", i + 1), 1'b0, 2'd0, 1'b0, 0);
      end

      // Saturation: each flip-plus-five-clean round costs exactly 3 errors
      applyStimulus(1'b1, 1'b0, 1'b0);
      gIdx = 0;
      for (int i = 0; i < 15; i++) feedGen(1'b0);
      checkOutput("sat locked", 1'b1, 2'd2, 1'b0, 0);
      for (int k = 0; k < 85; k++) begin
         feedGen(1'b1);
         for (int i = 0; i < 5; i++) feedGen(1'b0);
         checkOutput($sformatf("sat round%0d", k), 1'b1, 2'd2, 1'b0, 3 * (k + 1));
      end
      feedGen(1'b1);
      checkOutput("sat extra", 1'b1, 2'd2, 1'b1, 255);
      feedGen(1'b0);
      feedGen(1'b0);
      checkOutput("sat hold", 1'b1, 2'd2, 1'b0, 255);

      // clr with din_valid while locked: reset wins
      applyStimulus(1'b1, 1'b1, genBits[gIdx % 15] ^ 1'b1);
      checkOutput("clr locked", 1'b0, 2'd0, 1'b0, 0);

      // Reseed starts again from count 0
      gIdx = 0;
      for (int i = 0; i < 3; i++) feedGen(1'b0);
      checkOutput("reseed bit3", 1'b0, 2'd0, 1'b0, 0);
      feedGen(1'b0);
      checkOutput("reseed bit4", 1'b0, 2'd1, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
